ssc_slave: RTL

SSC_SLAVE -- requirements
Module: ssc_slave

---
 rtl/ssc_pkg.sv | 27 ++
 rtl/ssc_edge_sync.sv | 32 +++
 rtl/ssc_slave.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ssc_pkg.sv
// Purpose : shared constants, FSM state encoding and length helper for the SSC slave.
// Latency : n/a (declarations only).
// Backpressure: n/a; the SSC master owns the bus clock and cannot be stalled.
package ssc_pkg;

  localparam int CMD_W  = 5;   // command bits per frame
  localparam int DATA_W = 48;  // widest data word
  localparam int LEN_W  = 6;   // width of the length field

  typedef enum logic [2:0] {
    IDLE,
    RX_CMD,
    DECODE,
    RX_DATA,
    TX_DATA,
    WAIT_END
  } sscState_t;

  // Lengths above the data word width are treated as a full word.
  function automatic logic [LEN_W-1:0] clampLen(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(DATA_W)) begin
      return LEN_W'(DATA_W);
    end
    return len;
  endfunction

endpackage

// File: rtl/ssc_edge_sync.sv
// Purpose : synchronizes one asynchronous SSC line and flags its edges.
// Latency : edge flags appear STAGES-1 CLK cycles after the input changes.
// Backpressure: none; edges are single-cycle flags that must be consumed at once.
// Ports   : clk, rstN (sync, active-low; chain resets to the bus idle level 1),
//           d (async input), lvl (synchronized level), rise/fall (one-cycle edge flags).
module ssc_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstN,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  // syncQ[0] is the first flop; syncQ[STAGES-1] is the oldest sample.
  logic [STAGES-1:0] syncQ;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      syncQ <= '1;
    end else begin
      syncQ <= {syncQ[STAGES-2:0], d};
    end
  end

  assign lvl  = syncQ[STAGES-1];
  assign rise = syncQ[STAGES-2] & ~syncQ[STAGES-1];
  assign fall = ~syncQ[STAGES-2] & syncQ[STAGES-1];

endmodule

// File: rtl/ssc_slave.sv
// Purpose : SSC bus slave: receives a 5-bit command, then receives or transmits up to 48 data bits.
// Latency : cmdValid 1 CLK after the 5th synchronized sscClk rise; read MSB driven the CLK after cmdValid.
// Backpressure: none; cmdDir/cmdLength/rdData must be valid in the cmdValid cycle.
// Ports   : CLK, RSTn (sync, active-low); sscClk/sscSync/sscDataIn from the master;
//           sscDataOut/sscDataOe to the bus; cmd/cmdValid, cmdDir/cmdLength/rdData,
//           wrData/wrValid and busy towards the core.
// Option  : define SSC_SLAVE_FRAME_ERR_EN to add frameErr (abort pulse) and frameErrCnt (saturating).
module ssc_slave
  import ssc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              sscClk,
  input  logic              sscSync,
  input  logic              sscDataIn,
  output logic              sscDataOut,
  output logic              sscDataOe,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmdValid,
  input  logic              cmdDir,
  input  logic [LEN_W-1:0]  cmdLength,
  input  logic [DATA_W-1:0] rdData,
  output logic [DATA_W-1:0] wrData,
  output logic              wrValid,
  output logic              busy
`ifdef SSC_SLAVE_FRAME_ERR_EN
  ,
  output logic              frameErr,
  output logic [7:0]        frameErrCnt
`endif
);

  logic clkRise, clkFall, syncRise, syncFall, dataLvl;
  logic unusedClkLvl, unusedSyncLvl, unusedDataRise, unusedDataFall;

  ssc_edge_sync #(.STAGES(SYNC_STAGES)) clkSync (
    .clk (CLK), .rstN(RSTn), .d(sscClk),
    .lvl (unusedClkLvl), .rise(clkRise), .fall(clkFall)
  );

  ssc_edge_sync #(.STAGES(SYNC_STAGES)) frameSync (
    .clk (CLK), .rstN(RSTn), .d(sscSync),
    .lvl (unusedSyncLvl), .rise(syncRise), .fall(syncFall)
  );

  ssc_edge_sync #(.STAGES(SYNC_STAGES)) dataSync (
    .clk (CLK), .rstN(RSTn), .d(sscDataIn),
    .lvl (dataLvl), .rise(unusedDataRise), .fall(unusedDataFall)
  );

  sscState_t         state, stateNxt;
  logic [LEN_W-1:0]  bitCnt, bitCntNxt;
  logic [LEN_W-1:0]  lenQ, lenNxt;
  logic [CMD_W-1:0]  cmdShift, cmdShiftNxt, cmdNxt;
  logic [DATA_W-1:0] wrShift, wrShiftNxt, wrDataNxt;
  logic [DATA_W-1:0] txShift, txShiftNxt;
  logic              wrValidNxt, abortNxt;
  logic [LEN_W-1:0]  decodeLen;
  logic [DATA_W-1:0] wrShifted;
  logic [CMD_W-1:0]  cmdShifted;
  logic [1:0]        settleCnt;
  logic              settled;

  // The synchronizers reset to 1; if sscSync is low when reset releases, the
  // chain would present a false falling edge. Frame starts are ignored until
  // the chain has been flushed with real input samples.
  assign settled = (settleCnt == 2'(SYNC_STAGES));

  assign decodeLen  = clampLen(cmdLength);
  assign wrShifted  = {wrShift[DATA_W-2:0], dataLvl};
  assign cmdShifted = {cmdShift[CMD_W-2:0], dataLvl};

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= IDLE;
      bitCnt    <= '0;
      lenQ      <= '0;
      cmdShift  <= '0;
      cmd       <= '0;
      wrShift   <= '0;
      wrData    <= '0;
      txShift   <= '0;
      wrValid   <= 1'b0;
      settleCnt <= '0;
    end else begin
      state    <= stateNxt;
      bitCnt   <= bitCntNxt;
      lenQ     <= lenNxt;
      cmdShift <= cmdShiftNxt;
      cmd      <= cmdNxt;
      wrShift  <= wrShiftNxt;
      wrData   <= wrDataNxt;
      txShift  <= txShiftNxt;
      wrValid  <= wrValidNxt;
      if (!settled) begin
        settleCnt <= settleCnt + 2'd1;
      end
    end
  end

  always_comb begin
    stateNxt    = state;
    bitCntNxt   = bitCnt;
    lenNxt      = lenQ;
    cmdShiftNxt = cmdShift;
    cmdNxt      = cmd;
    wrShiftNxt  = wrShift;
    wrDataNxt   = wrData;
    txShiftNxt  = txShift;
    wrValidNxt  = 1'b0;
    abortNxt    = 1'b0;

    case (state)
      IDLE: begin
        if (syncFall && settled) begin
          stateNxt  = RX_CMD;
          bitCntNxt = LEN_W'(CMD_W - 1);
        end
      end

      // Sync rise is checked before clock edges so an abort wins a tie.
      RX_CMD: begin
        if (syncRise) begin
          stateNxt = IDLE;
          abortNxt = 1'b1;
        end else if (clkRise) begin
          cmdShiftNxt = cmdShifted;
          if (bitCnt == '0) begin
            cmdNxt   = cmdShifted;
            stateNxt = DECODE;
          end else begin
            bitCntNxt = bitCnt - LEN_W'(1);
          end
        end
      end

      DECODE: begin
        lenNxt     = decodeLen;
        wrShiftNxt = '0;
        // A frame closed during this single cycle would otherwise leave the
        // FSM waiting for clocks that never come.
        if (syncRise) begin
          stateNxt = IDLE;
        end else if (decodeLen == '0) begin
          stateNxt = WAIT_END;
        end else if (cmdDir) begin
          stateNxt  = RX_DATA;
          bitCntNxt = decodeLen - LEN_W'(1);
        end else begin
          stateNxt   = TX_DATA;
          bitCntNxt  = decodeLen;
          txShiftNxt = rdData << (LEN_W'(DATA_W) - decodeLen);
        end
      end

      RX_DATA: begin
        if (syncRise) begin
          stateNxt = IDLE;
          abortNxt = 1'b1;
        end else if (clkRise) begin
          wrShiftNxt = wrShifted;
          if (bitCnt == '0) begin
            wrDataNxt  = wrShifted;
            wrValidNxt = 1'b1;
            stateNxt   = WAIT_END;
          end else begin
            bitCntNxt = bitCnt - LEN_W'(1);
          end
        end
      end

      // The first falling edge here is the one that closes the last command
      // bit; it launches bit 0, already on the line, so it does not shift.
      // The falling edge after the last data bit releases the line.
      TX_DATA: begin
        if (syncRise) begin
          stateNxt = IDLE;
          abortNxt = 1'b1;
        end else if (clkFall) begin
          if (bitCnt == '0) begin
            stateNxt = WAIT_END;
          end else begin
            if (bitCnt != lenQ) begin
              txShiftNxt = txShift << 1;
            end
            bitCntNxt = bitCnt - LEN_W'(1);
          end
        end
      end

      WAIT_END: begin
        if (syncRise) begin
          stateNxt = IDLE;
        end
      end

      default: stateNxt = IDLE;
    endcase
  end

  assign cmdValid   = (state == DECODE);
  assign sscDataOe  = (state == TX_DATA);
  assign sscDataOut = sscDataOe & txShift[DATA_W-1];
  assign busy       = (state != IDLE);

`ifdef SSC_SLAVE_FRAME_ERR_EN
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      frameErr    <= 1'b0;
      frameErrCnt <= '0;
    end else begin
      frameErr <= abortNxt;
      if (abortNxt && (frameErrCnt != 8'hFF)) begin
        frameErrCnt <= frameErrCnt + 8'd1;
      end
    end
  end
`else
  logic unusedAbort;
  assign unusedAbort = abortNxt;
`endif

endmodule
